// File: rtl/seq_array_mul.sv
// seq_array_mul: iterative array multiplier folding R partial-product rows per clock.
// Optional feature macro: SEQ_MUL_SIGNED_EN adds the sgn port for two's-complement operands.
module seq_array_mul #(
   parameter int N = 8,
   parameter int R = 1
) (
   input  logic           clk,
   input  logic           clr_n,
   input  logic [N-1:0]   data_in,
   input  logic           load_a,
   input  logic           load_b,
   input  logic           start,
`ifdef SEQ_MUL_SIGNED_EN
   input  logic           sgn,
`endif
   output logic [2*N-1:0] product,
   output logic           busy,
   output logic           done
);
   localparam int ROWS = N / R;
   localparam int CW   = $clog2(ROWS) + 1;
   localparam int IW   = (N > 1) ? $clog2(N) : 1;

   if (N < 2 || R < 1 || R > N || (N % R) != 0) begin : g_bad_params
      $error("seq_array_mul: need N >= 2, 1 <= R <= N and N %% R == 0");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     a_q, b_q;
   logic [N-1:0]     wa_q, wa_d, wb_q, wb_d;
   logic [2*N-1:0]   acc_q, acc_d, prod_q, prod_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             flag;
   logic             last;
   logic [2*N-1:0]   ext_a;
   logic [2*N-1:0]   sum;
   logic [IW-1:0]    idx;

`ifdef SEQ_MUL_SIGNED_EN
   logic sgn_q, sgn_d;
   assign flag = sgn_q;
`else
   assign flag = 1'b0;
`endif

   assign ext_a   = flag ? {{N{wa_q[N-1]}}, wa_q} : {{N{1'b0}}, wa_q};
   assign last    = cnt_q == CW'(ROWS - 1);
   assign busy    = state_q == RUN;
   assign done    = done_q;
   assign product = prod_q;

   // Accumulate this cycle's R rows; the sign row is subtracted in two's-complement mode.
   always_comb begin
      sum = acc_q;
      idx = '0;
      for (int j = 0; j < R; j++) begin
         idx = IW'(int'(cnt_q) * R + j);
         if (wb_q[idx])
            sum = (flag && idx == IW'(N - 1)) ? sum - (ext_a << idx) : sum + (ext_a << idx);
      end
   end

   // Next-state logic: IDLE latches operands on start, RUN folds rows until the last one.
   always_comb begin
      state_d = state_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      sgn_d   = sgn_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               wa_d    = a_q;
               wb_d    = b_q;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
               sgn_d   = sgn;
`endif
               state_d = RUN;
            end
         end
         default: begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               prod_d  = sum;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

   // Operand registers load independently of the sequencer, even while busy.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (load_a) a_q <= data_in;
         if (load_b) b_q <= data_in;
      end
   end

   // Sequencer and datapath state; reset aborts any running multiply.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         wa_q    <= '0;
         wb_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
         sgn_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         wa_q    <= wa_d;
         wb_q    <= wb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
`ifdef SEQ_MUL_SIGNED_EN
         sgn_q   <= sgn_d;
`endif
      end
   end
endmodule

// File: tb/tb_seq_array_mul.sv
// tb_seq_array_mul: randomized self-checking bench for three seq_array_mul configurations.
module tb_seq_array_mul;
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  din [3];
   logic        la [3], lb [3], st [3];
   logic [15:0] p0, p1;
   logic [7:0]  p2;
   logic        b0, b1, b2, d0, d1, d2;
`ifdef SEQ_MUL_SIGNED_EN
   logic        sg [3];
`endif
   int n_chk = 0;
   int n_fail = 0;

   seq_array_mul #(.N(8), .R(1)) dut_a (
      .clk(clk), .clr_n(clr_n), .data_in(din[0]), .load_a(la[0]), .load_b(lb[0]), .start(st[0]),
`ifdef SEQ_MUL_SIGNED_EN
      .sgn(sg[0]),
`endif
      .product(p0), .busy(b0), .done(d0));

   seq_array_mul #(.N(8), .R(2)) dut_b (
      .clk(clk), .clr_n(clr_n), .data_in(din[1]), .load_a(la[1]), .load_b(lb[1]), .start(st[1]),
`ifdef SEQ_MUL_SIGNED_EN
      .sgn(sg[1]),
`endif
      .product(p1), .busy(b1), .done(d1));

   seq_array_mul #(.N(4), .R(4)) dut_c (
      .clk(clk), .clr_n(clr_n), .data_in(din[2][3:0]), .load_a(la[2]), .load_b(lb[2]), .start(st[2]),
`ifdef SEQ_MUL_SIGNED_EN
      .sgn(sg[2]),
`endif
      .product(p2), .busy(b2), .done(d2));

   function automatic logic [15:0] prd(int id);
      return id == 0 ? p0 : id == 1 ? p1 : {8'h00, p2};
   endfunction
   function automatic logic bsy(int id);
      return id == 0 ? b0 : id == 1 ? b1 : b2;
   endfunction
   function automatic logic dn(int id);
      return id == 0 ? d0 : id == 1 ? d1 : d2;
   endfunction
   function automatic int nrows(int id);
      return id == 0 ? 8 : id == 1 ? 4 : 1;
   endfunction
   function automatic int width(int id);
      return id == 2 ? 4 : 8;
   endfunction

   // Reference: plain integer product of the operands interpreted per the sign mode.
   function automatic logic [15:0] model(int id, int a, int b, bit s);
      int w = width(id);
      int m = (1 << w) - 1;
      int va = a & m;
      int vb = b & m;
      int full;
      if (s && va >= (1 << (w - 1))) va = va - (1 << w);
      if (s && vb >= (1 << (w - 1))) vb = vb - (1 << w);
      full = va * vb;
      return 16'(full & ((1 << (2 * w)) - 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(int id, logic [7:0] a, logic [7:0] b);
      din[id] = a; la[id] = 1'b1; tick(); la[id] = 1'b0;
      din[id] = b; lb[id] = 1'b1; tick(); lb[id] = 1'b0;
   endtask

   task automatic pulse_start(int id, bit s);
`ifdef SEQ_MUL_SIGNED_EN
      sg[id] = s;
`else
      if (s) $display("note: signed mode unavailable in this build");
`endif
      st[id] = 1'b1; tick(); st[id] = 1'b0;
   endtask

   // Called lat0 edges after the start edge; follows the run until done or a cycle budget expires.
   task automatic wait_check(int id, int lat0, logic [15:0] exp, logic [15:0] prev, string nm);
      int lat = lat0;
      forever begin
         if (dn(id) || lat >= 40) break;
         n_chk++;
         if (bsy(id) !== 1'b1 || prd(id) !== prev) begin
            n_fail++;
            $display("FAIL %s run cycle %0d: busy=%b product=%h, required busy=1 product=%h", nm, lat, bsy(id), prd(id), prev);
         end
         tick(); lat++;
      end
      n_chk++;
      if (lat != nrows(id)) begin
         n_fail++;
         $display("FAIL %s latency: got %0d edges, required %0d", nm, lat, nrows(id));
      end
      n_chk++;
      if (bsy(id) !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy at done: got %b, required 0", nm, bsy(id));
      end
      n_chk++;
      if (prd(id) !== exp) begin
         n_fail++;
         $display("FAIL %s product: got %h, required %h", nm, prd(id), exp);
      end
   endtask

   task automatic check_quiet(int id, string nm);
      n_chk++;
      if (dn(id) !== 1'b0 || bsy(id) !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle: done=%b busy=%b, required 0 0", nm, dn(id), bsy(id));
      end
   endtask

   task automatic run_mul(int id, logic [7:0] a, logic [7:0] b, bit s, string nm);
      logic [15:0] prev;
      load(id, a, b);
      prev = prd(id);
      pulse_start(id, s);
      wait_check(id, 0, model(id, a, b, s), prev, nm);
      tick();
      check_quiet(id, {nm, "_after"});
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         din[i] = '0; la[i] = 0; lb[i] = 0; st[i] = 0;
`ifdef SEQ_MUL_SIGNED_EN
         sg[i] = 0;
`endif
      end
      #12;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (prd(i) !== 16'h0 || bsy(i) !== 1'b0 || dn(i) !== 1'b0) begin
            n_fail++;
            $display("FAIL reset id%0d: product=%h busy=%b done=%b, required 0 0 0", i, prd(i), bsy(i), dn(i));
         end
      end
      @(negedge clk);
      clr_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      run_mul(0, 8'd13, 8'd11, 0, "r1_13x11");
      run_mul(2, 8'd15, 8'd15, 0, "r4_15x15");
   endtask

   task automatic test_back_to_back();
      logic [15:0] prev;
      load(1, 8'd255, 8'd255);
      prev = prd(1);
      pulse_start(1, 0);
      din[1] = 8'd0; lb[1] = 1'b1; tick(); lb[1] = 1'b0;
      wait_check(1, 1, 16'hFE01, prev, "b2b_first");
      pulse_start(1, 0);
      wait_check(1, 0, 16'h0000, 16'hFE01, "b2b_second");
      tick();
      check_quiet(1, "b2b_after");
   endtask

   task automatic test_busy_ignore();
      logic [15:0] prev;
      load(0, 8'd13, 8'd11);
      prev = prd(0);
      pulse_start(0, 0);
      din[0] = 8'd7; la[0] = 1'b1; st[0] = 1'b1; tick(); la[0] = 1'b0; st[0] = 1'b0;
      wait_check(0, 1, 16'd143, prev, "ignore_first");
      for (int i = 0; i < 4; i++) begin
         tick();
         check_quiet(0, "ignore_norestart");
      end
      pulse_start(0, 0);
      wait_check(0, 0, 16'd77, 16'd143, "ignore_next");
      tick();
   endtask

   task automatic test_load_with_start();
      load(0, 8'd9, 8'd5);
      din[0] = 8'd3; la[0] = 1'b1; st[0] = 1'b1; tick(); la[0] = 1'b0; st[0] = 1'b0;
      wait_check(0, 0, 16'd45, 16'd77, "same_edge_old");
      tick();
      pulse_start(0, 0);
      wait_check(0, 0, 16'd15, 16'd45, "same_edge_new");
      tick();
   endtask

   task automatic test_random();
      for (int id = 0; id < 3; id++)
         for (int k = 0; k < 8; k++)
            run_mul(id, 8'($urandom), 8'($urandom), 0, $sformatf("rand_id%0d_%0d", id, k));
   endtask

   task automatic test_reset_mid_run();
      load(0, 8'd13, 8'd11);
      pulse_start(0, 0);
      tick(); tick();
      #2 clr_n = 1'b0;
      #1;
      n_chk++;
      if (bsy(0) !== 1'b0 || dn(0) !== 1'b0 || prd(0) !== 16'h0) begin
         n_fail++;
         $display("FAIL midrun_reset: busy=%b done=%b product=%h, required 0 0 0", bsy(0), dn(0), prd(0));
      end
      @(negedge clk);
      clr_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_quiet(0, "midrun_no_done");
      end
      run_mul(0, 8'd6, 8'd7, 0, "after_reset");
   endtask

`ifdef SEQ_MUL_SIGNED_EN
   task automatic test_signed();
      run_mul(0, 8'hFD, 8'h05, 1, "sgn_m3x5");
      run_mul(0, 8'h80, 8'h80, 1, "sgn_80x80");
      run_mul(0, 8'h80, 8'h80, 0, "uns_80x80");
      run_mul(0, 8'hFD, 8'h05, 0, "uns_fdx05");
      for (int k = 0; k < 8; k++)
         run_mul(k % 3, 8'($urandom), 8'($urandom), 1, $sformatf("sgn_rand_%0d", k));
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_busy_ignore();
      test_load_with_start();
      test_random();
      test_reset_mid_run();
`ifdef SEQ_MUL_SIGNED_EN
      test_signed();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
